// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: bundles the host push port and the uart_tx facing port of
// uart_tx_fifo.
//   slave  modport : the FIFO (takes wr_en/wr_data/empty_tsr, drives status/data/vld_tx)
//   master modport : host + uart_tx side (drives wr_en/wr_data/empty_tsr)
// Optional feature macro: UART_TXFIFO_OVF_STICKY_EN adds ovf_clr / wr_ovf.
// Ports carried:
//   wr_en     push request, one byte per cycle
//   wr_data   byte to push
//   wr_full   level == DEPTH
//   wr_afull  level >= AFULL_TH
//   wr_empty  level == 0
//   wr_level  entries held (AW+1 bits), including the head on offer
//   data      head byte offered to uart_tx
//   vld_tx    head byte valid
//   empty_tsr from uart_tx, 1 = transmit shift register free
//   ovf_clr   (optional) clears the sticky overflow flag
//   wr_ovf    (optional) sticky flag, a push was dropped while full
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          wr_full;
  logic          wr_afull;
  logic          wr_empty;
  logic [AW:0]   wr_level;
  logic [7:0]    data;
  logic          vld_tx;
  logic          empty_tsr;

`ifdef UART_TXFIFO_OVF_STICKY_EN
  logic          ovf_clr;
  logic          wr_ovf;

  modport slave (
    input  wr_en, wr_data, empty_tsr, ovf_clr,
    output wr_full, wr_afull, wr_empty, wr_level, data, vld_tx, wr_ovf
  );

  modport master (
    output wr_en, wr_data, empty_tsr, ovf_clr,
    input  wr_full, wr_afull, wr_empty, wr_level, data, vld_tx, wr_ovf
  );
`else
  modport slave (
    input  wr_en, wr_data, empty_tsr,
    output wr_full, wr_afull, wr_empty, wr_level, data, vld_tx
  );

  modport master (
    output wr_en, wr_data, empty_tsr,
    input  wr_full, wr_afull, wr_empty, wr_level, data, vld_tx
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO sitting directly upstream of uart_tx.
// The host pushes bytes through bus.wr_en/bus.wr_data. The head byte is offered
// on bus.data/bus.vld_tx and held stable until uart_tx loads its TSR, seen as a
// 1->0 edge on bus.empty_tsr; the entry is then popped. This lets the host queue
// a burst while the serializer runs at baud rate.
// Timing: an input driven after edge N is sampled at N+1. A push into an empty
// FIFO driven after edge N raises vld_tx with valid data at N+2; an empty_tsr
// fall driven after edge M drops vld_tx at M+1 and frees the entry at M+2.
// Parameters:
//   DEPTH    entries, power of 2, >= 4
//   AFULL_TH wr_afull threshold (wr_level >= AFULL_TH)
// Ports:
//   clk   system clock
//   rstn  asynchronous active-low reset
//   bus   uart_tx_fifo_if.slave (push port, status, head byte, empty_tsr)
// Optional feature macro: UART_TXFIFO_OVF_STICKY_EN
//   defined  : sticky bus.wr_ovf, set one cycle after a push is dropped while
//              full, cleared by bus.ovf_clr; a new drop beats a clear.
//   undefined: drops while full are silent.
module uart_tx_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AFULL_TH = DEPTH - 2
) (
  input  logic          clk,
  input  logic          rstn,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_POP   = 2'd2
  } state_e;

  // Storage and pointers (extra MSB is the wrap bit)
  logic [7:0]    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  // Combinational helpers
  logic [AW:0]   level_c;
  logic [AW:0]   level_d;
  logic          full_c;
  logic          push_c;
  logic          pop_c;
  logic          tsr_fall_c;
  logic          load_c;
  logic [AW-1:0] rd_addr_c;

  // FSM and registered outputs
  state_e        state_q, state_d;
  logic          empty_q;
  logic [7:0]    data_q, data_d;
  logic          vld_q, vld_d;
  logic          wr_full_q;
  logic          wr_afull_q;
  logic          wr_empty_q;
  logic [AW:0]   level_q;

  // Occupancy from the current (pre-edge) pointers
  assign level_c = wr_ptr_q - rd_ptr_q;
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push while full is dropped; a pop happens on the edge that leaves POP
  assign push_c   = bus.wr_en & ~full_c;
  assign pop_c    = (state_q == ST_POP);
  assign wr_ptr_d = wr_ptr_q + PW'(push_c);
  assign rd_ptr_d = rd_ptr_q + PW'(pop_c);
  assign level_d  = wr_ptr_d - rd_ptr_d;

  // uart_tx took the byte: empty_tsr went 1 -> 0
  assign tsr_fall_c = empty_q & ~bus.empty_tsr;

  // Next state, head-load request and registered output values
  always_comb begin
    state_d   = state_q;
    load_c    = 1'b0;
    rd_addr_c = rd_ptr_q[AW-1:0];
    vld_d     = 1'b0;
    data_d    = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (level_c != '0) begin
          state_d = ST_OFFER;
          load_c  = 1'b1;
        end
      end
      ST_OFFER: begin
        if (tsr_fall_c) begin
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        // rd_ptr still points at the byte being retired; the next head is one past it
        rd_addr_c = rd_ptr_q[AW-1:0] + AW'(1);
        if (level_c > PW'(1)) begin
          state_d = ST_OFFER;
          load_c  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    vld_d = (state_d == ST_OFFER);
    if (load_c) begin
      data_d = mem_q[rd_addr_c];
    end
  end

  // Storage write (no reset needed on the array)
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
    end
  end

  // Pointers, FSM, edge register and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= ST_IDLE;
      empty_q    <= 1'b1;
      data_q     <= 8'h00;
      vld_q      <= 1'b0;
      wr_full_q  <= 1'b0;
      wr_afull_q <= 1'b0;
      wr_empty_q <= 1'b1;
      level_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      empty_q    <= bus.empty_tsr;
      data_q     <= data_d;
      vld_q      <= vld_d;
      wr_full_q  <= (level_d == PW'(DEPTH));
      wr_afull_q <= (level_d >= PW'(AFULL_TH));
      wr_empty_q <= (level_d == '0);
      level_q    <= level_d;
    end
  end

`ifdef UART_TXFIFO_OVF_STICKY_EN
  logic ovf_q;

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= (bus.wr_en & full_c) | (ovf_q & ~bus.ovf_clr);
    end
  end

  assign bus.wr_ovf = ovf_q;
`endif

  assign bus.data     = data_q;
  assign bus.vld_tx   = vld_q;
  assign bus.wr_full  = wr_full_q;
  assign bus.wr_afull = wr_afull_q;
  assign bus.wr_empty = wr_empty_q;
  assign bus.wr_level = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. A reference model tracks accepted bytes in a
// queue and occupancy as a count; a monitor plays the uart_tx side and compares
// every byte it takes, plus status every cycle, against the model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned AFULL_TH = DEPTH - 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];
  int         m_level = 0;
  int         pop_cd  = 0;
  bit         m_ovf   = 1'b0;
  bit         chk_drop = 1'b0;

  // uart_tx behaviour knobs
  bit         uart_stall = 1'b1;
  int         accept_pct = 100;
  int         spur_pct   = 0;
  int         busy_cnt   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: occupancy and contents at each rising edge
  initial begin
    bit acc;
    bit pop_now;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        exp_q.delete();
        m_level  = 0;
        pop_cd   = 0;
        m_ovf    = 1'b0;
        chk_drop = 1'b0;
      end else begin
        acc     = bus.wr_en && (m_level < int'(DEPTH));
        pop_now = 1'b0;
        if (pop_cd != 0) begin
          pop_cd--;
          pop_now = (pop_cd == 0);
        end
`ifdef UART_TXFIFO_OVF_STICKY_EN
        m_ovf = (bus.wr_en && !acc) || (m_ovf && !bus.ovf_clr);
`endif
        if (acc) exp_q.push_back(bus.wr_data);
        m_level = m_level + int'(acc) - int'(pop_now);
      end
    end
  end

  // Monitor + uart_tx model, on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("level", 32'(bus.wr_level), 32'(m_level));
        chk("full",  32'(bus.wr_full),  32'(m_level == int'(DEPTH)));
        chk("afull", 32'(bus.wr_afull), 32'(m_level >= int'(AFULL_TH)));
        chk("empty", 32'(bus.wr_empty), 32'(m_level == 0));
`ifdef UART_TXFIFO_OVF_STICKY_EN
        chk("ovf", 32'(bus.wr_ovf), 32'(m_ovf));
`endif
        if (chk_drop) begin
          chk("vld_drop_after_load", 32'(bus.vld_tx), 32'(0));
          chk_drop = 1'b0;
        end
        if (bus.vld_tx) begin
          chk("head_available", 32'(exp_q.size() != 0), 32'(1));
          if (exp_q.size() != 0) chk("head_data", 32'(bus.data), 32'(exp_q[0]));
        end
      end
      // uart_tx: finishes its own frame regardless of reset
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) bus.empty_tsr = 1'b1;
      end else if (bus.empty_tsr) begin
        if (rstn && bus.vld_tx && !uart_stall && ($urandom_range(0, 99) < accept_pct)) begin
          chk("tx_nonempty", 32'(exp_q.size() != 0), 32'(1));
          if (exp_q.size() != 0) begin
            chk("tx_byte", 32'(bus.data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
          end
          tx_log.push_back(bus.data);
          pop_cd        = 2;
          chk_drop      = 1'b1;
          bus.empty_tsr = 1'b0;
          busy_cnt      = $urandom_range(1, 6);
        end else if (!bus.vld_tx && ($urandom_range(0, 99) < spur_pct)) begin
          // TSR loaded from elsewhere while nothing is offered: must not pop
          bus.empty_tsr = 1'b0;
          busy_cnt      = $urandom_range(1, 4);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (m_level == 0) && (exp_q.size() == 0) && (busy_cnt == 0);
    end
    chk(nm, 32'(done), 32'(1));
  endtask

  // Stimulus
  initial begin
    int sent;
    int n_pp;
    int lvl_before;
    bit do_push;
    bit pp;

    bus.wr_en     = 1'b0;
    bus.wr_data   = 8'h00;
    bus.empty_tsr = 1'b1;
`ifdef UART_TXFIFO_OVF_STICKY_EN
    bus.ovf_clr   = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_vld",   32'(bus.vld_tx),   32'(0));
    chk("rst_data",  32'(bus.data),     32'(0));
    chk("rst_full",  32'(bus.wr_full),  32'(0));
    chk("rst_afull", 32'(bus.wr_afull), 32'(0));
    chk("rst_empty", 32'(bus.wr_empty), 32'(1));
    chk("rst_level", 32'(bus.wr_level), 32'(0));
`ifdef UART_TXFIFO_OVF_STICKY_EN
    chk("rst_ovf",   32'(bus.wr_ovf),   32'(0));
`endif
    #2 rstn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_no_vld", 32'(bus.vld_tx), 32'(0));
    end

    // Single byte: two-edge latency, then a modelled load
    push_byte(8'hA5);
    chk("lat1_vld", 32'(bus.vld_tx), 32'(0));
    @(negedge clk);
    chk("lat2_vld",  32'(bus.vld_tx), 32'(1));
    chk("lat2_data", 32'(bus.data),   32'(8'hA5));
    uart_stall = 1'b0;
    drain("single_drain", 200);
    chk("single_level", 32'(bus.wr_level), 32'(0));

    // Burst to full, 17th push dropped, order preserved
    uart_stall = 1'b1;
    tx_log.delete();
    for (int i = 0; i < 16; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      @(negedge clk);
    end
    chk("burst_full", 32'(bus.wr_full), 32'(1));
    bus.wr_data = 8'hEE;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("burst_drop_level", 32'(bus.wr_level), 32'(16));
    chk("burst_head", 32'(bus.data), 32'(8'h00));
`ifdef UART_TXFIFO_OVF_STICKY_EN
    chk("ovf_set", 32'(bus.wr_ovf), 32'(1));
    repeat (3) begin
      @(negedge clk);
      chk("ovf_hold", 32'(bus.wr_ovf), 32'(1));
    end
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", 32'(bus.wr_ovf), 32'(0));
    bus.ovf_clr = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h77;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    bus.wr_en   = 1'b0;
    chk("ovf_set_wins", 32'(bus.wr_ovf), 32'(1));
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(bus.wr_ovf), 32'(0));
`endif
    uart_stall = 1'b0;
    drain("burst_drain", 400);
    chk("burst_count", 32'(tx_log.size()), 32'(16));
    for (int i = 0; i < 16; i++) begin
      if (i < tx_log.size()) chk("burst_order", 32'(tx_log[i]), 32'(i));
    end

    // Hold: offered byte stays put while empty_tsr stays high
    uart_stall = 1'b1;
    push_byte(8'h3C);
    push_byte(8'h4D);
    repeat (100) @(negedge clk);
    chk("hold_vld",   32'(bus.vld_tx),   32'(1));
    chk("hold_data",  32'(bus.data),     32'(8'h3C));
    chk("hold_level", 32'(bus.wr_level), 32'(2));
    uart_stall = 1'b0;
    drain("hold_drain", 200);

    // Steady level of 8 with pushes landing in POP cycles; pointers wrap
    uart_stall = 1'b1;
    for (int i = 0; i < 8; i++) push_byte(8'($urandom));
    uart_stall = 1'b0;
    accept_pct = 60;
    sent = 0;
    n_pp = 0;
    for (int cyc = 0; cyc < 3000 && sent < 40; cyc++) begin
      do_push     = (m_level < 8) || (pop_cd == 1);
      pp          = do_push && (pop_cd == 1);
      lvl_before  = m_level;
      bus.wr_en   = do_push;
      bus.wr_data = 8'($urandom);
      @(negedge clk);
      if (pp) begin
        chk("pop_push_level", 32'(bus.wr_level), 32'(lvl_before));
        n_pp++;
      end
      if (do_push) sent++;
    end
    bus.wr_en = 1'b0;
    chk("steady_sent", 32'(sent), 32'(40));
    chk("pop_push_seen", 32'(n_pp > 0), 32'(1));
    drain("steady_drain", 400);

    // Random traffic with spurious TSR loads and a reset mid-frame
    spur_pct = 5;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 700) begin
        bus.wr_en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("midrst_vld",   32'(bus.vld_tx),   32'(0));
        chk("midrst_level", 32'(bus.wr_level), 32'(0));
        chk("midrst_empty", 32'(bus.wr_empty), 32'(1));
        chk("midrst_full",  32'(bus.wr_full),  32'(0));
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("postrst_no_vld", 32'(bus.vld_tx), 32'(0));
        end
      end
      accept_pct  = (cyc < 350) ? 30 : 70;
      bus.wr_en   = ($urandom_range(0, 99) < 40);
      bus.wr_data = 8'($urandom);
`ifdef UART_TXFIFO_OVF_STICKY_EN
      bus.ovf_clr = ($urandom_range(0, 19) == 0);
`endif
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
`ifdef UART_TXFIFO_OVF_STICKY_EN
    bus.ovf_clr = 1'b0;
`endif
    spur_pct   = 0;
    accept_pct = 100;
    drain("random_drain", 3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if something never completes
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
